// File: rtl/cv32e40x_dbg_trace_buffer_pkg.sv
// Shared types for the debug trace buffer: entry layout and FSM states.
// Entry gains a timestamp field when CV32E40X_DBG_TRACE_TIMESTAMP_EN is defined.
package cv32e40x_pkg;

    localparam int DBG_TRACE_NRP = 2;

    typedef logic [4:0] rf_addr_t;

    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'h03,
        OPCODE_OPIMM  = 7'h13,
        OPCODE_AUIPC  = 7'h17,
        OPCODE_STORE  = 7'h23,
        OPCODE_OP     = 7'h33,
        OPCODE_LUI    = 7'h37,
        OPCODE_BRANCH = 7'h63,
        OPCODE_JALR   = 7'h67,
        OPCODE_JAL    = 7'h6f,
        OPCODE_SYSTEM = 7'h73
    } opcode_e;

    typedef enum logic [1:0] {
        RECORD = 2'd0,
        POST   = 2'd1,
        FROZEN = 2'd2
    } dbg_trace_state_e;

    typedef struct packed {
`ifdef CV32E40X_DBG_TRACE_TIMESTAMP_EN
        logic [31:0]                   timestamp;
`endif
        logic [31:0]                   instr;
        logic                          is_compressed;
        opcode_e                       opcode;
        logic [DBG_TRACE_NRP-1:0]      rf_re;
        rf_addr_t [DBG_TRACE_NRP-1:0]  rf_raddr;
        logic                          rf_we;
        rf_addr_t                      rf_waddr;
        logic                          illegal_insn;
    } dbg_trace_entry_t;

endpackage

// File: rtl/cv32e40x_dbg_trace_buffer_if.sv
// Drain port of the debug trace buffer: valid/ready with entry and last flag.
// master = buffer side, slave = consumer side.
interface cv32e40x_dbg_trace_buffer_if;
    import cv32e40x_pkg::*;

    logic             rd_valid_o;
    logic             rd_ready_i;
    dbg_trace_entry_t rd_entry_o;
    logic             rd_last_o;

    modport master (
        output rd_valid_o,
        output rd_entry_o,
        output rd_last_o,
        input  rd_ready_i
    );

    modport slave (
        input  rd_valid_o,
        input  rd_entry_o,
        input  rd_last_o,
        output rd_ready_i
    );

endinterface

// File: rtl/cv32e40x_dbg_trace_buffer_mem.sv
// Trace storage: DEPTH x entry flop array, one write port, one async read port.
// Contents are deliberately not reset.
module cv32e40x_dbg_trace_buffer_mem
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  dbg_trace_entry_t wdata,
    input  logic [AW-1:0]    raddr,
    output dbg_trace_entry_t rdata
);

    dbg_trace_entry_t mem_q [DEPTH];

    // Write the captured entry into its slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cv32e40x_dbg_trace_buffer.sv
// Circular ID-stage trace history, frozen on illegal insn or external request.
// Optional timestamp via CV32E40X_DBG_TRACE_TIMESTAMP_EN.
module cv32e40x_dbg_trace_buffer
    import cv32e40x_pkg::*;
#(
    parameter int REGFILE_NUM_READ_PORTS = DBG_TRACE_NRP,
    parameter int DEPTH                  = 16,
    parameter int POST_TRIG              = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              capture_valid_i,
    input  logic [31:0]                       instr_i,
    input  logic                              is_compressed_i,
    input  logic [REGFILE_NUM_READ_PORTS-1:0] rf_re_i,
    input  rf_addr_t                          rf_raddr_i [REGFILE_NUM_READ_PORTS],
    input  logic                              rf_we_i,
    input  rf_addr_t                          rf_waddr_i,
    input  logic                              illegal_insn_i,
    input  logic                              freeze_i,
    input  logic                              arm_i,
    cv32e40x_dbg_trace_buffer_if.master       rd,
    output logic                              frozen_o,
    output logic [$clog2(DEPTH):0]            count_o,
    output logic                              overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] POST_CNT = CW'(POST_TRIG);

    dbg_trace_state_e state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    post_q, post_d;
    logic             ovf_q, ovf_d;
    logic             we;
    logic             pop;
    logic [AW-1:0]    raddr;
    dbg_trace_entry_t wdata;
    dbg_trace_entry_t rdata;

`ifdef CV32E40X_DBG_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;

    // Free-running cycle counter sampled into each entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end
`endif

    // Assemble the entry, packing the unpacked read-address array.
    always_comb begin
        wdata               = '0;
        wdata.instr         = instr_i;
        wdata.is_compressed = is_compressed_i;
        wdata.opcode        = opcode_e'(instr_i[6:0]);
        wdata.rf_re         = rf_re_i;
        for (int i = 0; i < REGFILE_NUM_READ_PORTS; i++) begin
            wdata.rf_raddr[i] = rf_raddr_i[i];
        end
        wdata.rf_we         = rf_we_i;
        wdata.rf_waddr      = rf_waddr_i;
        wdata.illegal_insn  = illegal_insn_i;
`ifdef CV32E40X_DBG_TRACE_TIMESTAMP_EN
        wdata.timestamp     = ts_q;
`endif
    end

    assign rd.rd_valid_o = (state_q == FROZEN) && (count_q != '0);
    assign rd.rd_last_o  = rd.rd_valid_o && (count_q == CW'(1));
    assign rd.rd_entry_o = rd.rd_valid_o ? rdata : '0;
    assign pop           = rd.rd_valid_o && rd.rd_ready_i;
    // count==DEPTH truncates to 0, giving wptr itself as the oldest slot.
    assign raddr         = wptr_q - count_q[AW-1:0];

    // Next-state: arm wins; otherwise record/trigger/freeze or drain.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        post_d  = post_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        if (arm_i) begin
            state_d = RECORD;
            count_d = '0;
            post_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                RECORD, POST: begin
                    if (capture_valid_i) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + AW'(1);
                        if (count_q == FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                        if (state_q == RECORD && illegal_insn_i) begin
                            post_d  = POST_CNT;
                            state_d = (POST_TRIG == 0) ? FROZEN : POST;
                        end else if (state_q == POST) begin
                            post_d = post_q - CW'(1);
                            if (post_q == CW'(1)) begin
                                state_d = FROZEN;
                            end
                        end
                    end
                    if (freeze_i) begin
                        state_d = FROZEN;
                    end
                end
                FROZEN: begin
                    if (pop) begin
                        count_d = count_q - CW'(1);
                    end
                end
                default: begin
                    state_d = RECORD;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RECORD;
            wptr_q  <= '0;
            count_q <= '0;
            post_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            post_q  <= post_d;
            ovf_q   <= ovf_d;
        end
    end

    assign frozen_o   = (state_q == FROZEN);
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    cv32e40x_dbg_trace_buffer_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_cv32e40x_dbg_trace_buffer.sv
// Directed self-checking bench for the debug trace buffer.
// DEPTH=8, POST_TRIG=2, two read ports.
module tb_cv32e40x_dbg_trace_buffer;
    import cv32e40x_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        capture_valid;
    logic [31:0] instr;
    logic        is_compressed;
    logic [1:0]  rf_re;
    rf_addr_t    rf_raddr [2];
    logic        rf_we;
    rf_addr_t    rf_waddr;
    logic        illegal_insn;
    logic        freeze;
    logic        arm;
    logic        frozen;
    logic [3:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    dbg_trace_entry_t saved;

    cv32e40x_dbg_trace_buffer_if rd_if ();

    cv32e40x_dbg_trace_buffer #(
        .REGFILE_NUM_READ_PORTS (2),
        .DEPTH                  (8),
        .POST_TRIG              (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .capture_valid_i (capture_valid),
        .instr_i         (instr),
        .is_compressed_i (is_compressed),
        .rf_re_i         (rf_re),
        .rf_raddr_i      (rf_raddr),
        .rf_we_i         (rf_we),
        .rf_waddr_i      (rf_waddr),
        .illegal_insn_i  (illegal_insn),
        .freeze_i        (freeze),
        .arm_i           (arm),
        .rd              (rd_if),
        .frozen_o        (frozen),
        .count_o         (count),
        .overflow_o      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input int k, input logic ill, input logic frz,
                       input logic arm_in);
        capture_valid = 1'b1;
        instr         = 32'h13 + 32'(k);
        is_compressed = 1'b0;
        rf_re         = 2'b11;
        rf_raddr[0]   = rf_addr_t'(k);
        rf_raddr[1]   = rf_addr_t'(k + 1);
        rf_we         = 1'b1;
        rf_waddr      = rf_addr_t'(k + 2);
        illegal_insn  = ill;
        freeze        = frz;
        arm           = arm_in;
        step();
        capture_valid = 1'b0;
        illegal_insn  = 1'b0;
        freeze        = 1'b0;
        arm           = 1'b0;
    endtask

    task automatic pulse_freeze();
        freeze = 1'b1;
        step();
        freeze = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic drain(input int first, input int n);
        rd_if.rd_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("dr_valid", 64'(rd_if.rd_valid_o), 64'd1);
            chk("dr_instr", 64'(rd_if.rd_entry_o.instr),
                64'(32'h13 + 32'(first + i)));
            chk("dr_raddr0", 64'(rd_if.rd_entry_o.rf_raddr[0]),
                64'(first + i));
            chk("dr_last", 64'(rd_if.rd_last_o), 64'(i == n - 1));
            step();
        end
        rd_if.rd_ready_i = 1'b0;
        chk("dr_empty_valid", 64'(rd_if.rd_valid_o), 64'd0);
        chk("dr_empty_count", 64'(count), 64'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        capture_valid    = 1'b0;
        instr            = '0;
        is_compressed    = 1'b0;
        rf_re            = '0;
        rf_raddr[0]      = '0;
        rf_raddr[1]      = '0;
        rf_we            = 1'b0;
        rf_waddr         = '0;
        illegal_insn     = 1'b0;
        freeze           = 1'b0;
        arm              = 1'b0;
        rd_if.rd_ready_i = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // 1: reset state
        repeat (5) step();
        chk("rst_valid", 64'(rd_if.rd_valid_o), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_frozen", 64'(frozen), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_entry", 64'(rd_if.rd_entry_o == '0), 64'd1);
        chk("rst_last", 64'(rd_if.rd_last_o), 64'd0);

        // 2: five captures, freeze, drain in order
        for (int k = 0; k < 5; k++) cap(k, 1'b0, 1'b0, 1'b0);
        chk("t2_not_frozen", 64'(frozen), 64'd0);
        chk("t2_no_read", 64'(rd_if.rd_valid_o), 64'd0);
        pulse_freeze();
        chk("t2_frozen", 64'(frozen), 64'd1);
        chk("t2_count", 64'(count), 64'd5);
        drain(0, 5);
        chk("t2_hold_frozen", 64'(frozen), 64'd1);
        pulse_arm();
        chk("t2_arm_frozen", 64'(frozen), 64'd0);

        // 3: wrap with overflow
        for (int k = 0; k < 10; k++) cap(k, 1'b0, 1'b0, 1'b0);
        pulse_freeze();
        chk("t3_count", 64'(count), 64'd8);
        chk("t3_ovf", 64'(overflow), 64'd1);
        drain(2, 8);
        chk("t3_ovf_sticky", 64'(overflow), 64'd1);
        pulse_arm();
        chk("t3_arm_ovf", 64'(overflow), 64'd0);

        // 4: illegal trigger at k=3, two post entries
        for (int k = 0; k < 8; k++) begin
            cap(k, k == 3, 1'b0, 1'b0);
            if (k == 4) chk("t4_not_yet", 64'(frozen), 64'd0);
            if (k == 5) chk("t4_frozen", 64'(frozen), 64'd1);
        end
        chk("t4_count", 64'(count), 64'd6);
        chk("t4_ovf", 64'(overflow), 64'd0);
        chk("t4_ill_flag", 64'(rd_if.rd_entry_o.illegal_insn), 64'd0);
        drain(0, 6);
        pulse_arm();

        // 5: backpressure then arm mid-drain
        for (int k = 0; k < 4; k++) cap(k, 1'b0, 1'b0, 1'b0);
        pulse_freeze();
        saved = rd_if.rd_entry_o;
        chk("t5_first", 64'(saved.instr), 64'h13);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold", 64'(rd_if.rd_entry_o == saved), 64'd1);
            chk("t5_hold_count", 64'(count), 64'd4);
        end
        rd_if.rd_ready_i = 1'b1;
        step();
        chk("t5_pop_count", 64'(count), 64'd3);
        chk("t5_next", 64'(rd_if.rd_entry_o.instr), 64'h14);
        arm = 1'b1;
        step();
        arm = 1'b0;
        rd_if.rd_ready_i = 1'b0;
        chk("t5_arm_valid", 64'(rd_if.rd_valid_o), 64'd0);
        chk("t5_arm_count", 64'(count), 64'd0);
        chk("t5_arm_ovf", 64'(overflow), 64'd0);
        chk("t5_arm_frozen", 64'(frozen), 64'd0);
        cap(20, 1'b0, 1'b0, 1'b0);
        chk("t5_resume", 64'(count), 64'd1);

        // 6: capture + freeze + arm together
        cap(21, 1'b0, 1'b1, 1'b1);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_frozen", 64'(frozen), 64'd0);
        pulse_freeze();
        chk("t6_empty_frozen", 64'(frozen), 64'd1);
        chk("t6_empty_valid", 64'(rd_if.rd_valid_o), 64'd0);
        pulse_arm();

`ifdef CV32E40X_DBG_TRACE_TIMESTAMP_EN
        cap(30, 1'b0, 1'b0, 1'b0);
        step();
        cap(31, 1'b0, 1'b1, 1'b0);
        saved = rd_if.rd_entry_o;
        rd_if.rd_ready_i = 1'b1;
        step();
        rd_if.rd_ready_i = 1'b0;
        chk("ts_delta", 64'(rd_if.rd_entry_o.timestamp - saved.timestamp),
            64'd2);
        pulse_arm();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
